// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared definitions for the adder_arbiter block.
//   - state_e         : sequencer states (IDLE, CALC, HOLD)
//   - ADDER_W_DEFAULT : default operand / sum width
//   - idw()           : requester-index width for a given requester count
package adder_arb_pkg;

  localparam int ADDER_W_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_arbiter_rr_picker.sv
// rr_picker: combinational round-robin one-hot picker.
// Ports:
//   valid  in  NREQ  request vector
//   ptr    in  IDW   highest-priority index; search wraps NREQ-1 -> 0
//   grant  out NREQ  one-hot first valid at/after ptr, zero if none valid
module rr_picker
  import adder_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = idw(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant
);

  logic found;

  // Priority level k belongs to requester i when i == (ptr + k) mod NREQ,
  // i.e. ptr == (i - k) mod NREQ; comparing against constants keeps every
  // index static.
  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && valid[i] && (ptr == IDW'((i - k + NREQ) % NREQ))) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ripple_adder.sv
// ripple_adder: the existing W-bit ripple-carry adder datapath (combinational).
// Ports:
//   a_i, b_i  in  W  operands
//   cin_i     in  1  carry-in
//   sum_o     out W  a + b + cin, modulo 2^W
//   cout_o    out 1  carry-out of the top bit
module ripple_adder #(
  parameter int W = 64
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic carry;

  // NOTE: blocking assignments in always_comb are intentional; each loop
  // iteration must see the carry produced by the previous bit.
  always_comb begin
    carry = cin_i;
    sum_o = '0;
    for (int i = 0; i < W; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry;
  end

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter and sequencer sharing one ripple adder
// among NREQ requesters. Each request is captured (IDLE), added (CALC) and
// held until the consumer accepts it (HOLD); results carry the requester id.
// Build option: define ADDER_ARB_ACCUM_EN to add the req_acc port and one
// running-sum register per requester that can replace operand B.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   req_valid  in  NREQ    per-requester request strobe
//   req_ready  out NREQ    one-hot grant (combinational, IDLE only)
//   req_a/b    in  NREQ*W  operands, requester i at [i*W +: W]
//   req_cin    in  NREQ    carry-in per requester
//   req_acc    in  NREQ    use accumulator as B (ADDER_ARB_ACCUM_EN only)
//   rsp_valid  out 1       result held
//   rsp_ready  in  1       consumer accepts result
//   rsp_id     out IDW     requester index of the result
//   rsp_sum    out W       registered sum
//   rsp_cout   out 1       registered carry-out
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = ADDER_W_DEFAULT,
  localparam int IDW = idw(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
`ifdef ADDER_ARB_ACCUM_EN
  input  logic [NREQ-1:0]   req_acc,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout
);

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           cin_q, cin_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
`ifdef ADDER_ARB_ACCUM_EN
  logic [NREQ-1:0][W-1:0] acc_q, acc_d;
`endif

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  sel_id;
  logic [W-1:0]    sel_a, sel_b;
  logic            sel_cin;
  logic [W-1:0]    add_sum;
  logic            add_cout;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  ripple_adder #(.W(W)) u_adder (
    .a_i    (a_q),
    .b_i    (b_q),
    .cin_i  (cin_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // Operand mux for the granted requester (grant is one-hot or zero).
  always_comb begin
    sel_id  = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_id  = IDW'(i);
        sel_a   = req_a[i*W +: W];
        sel_b   = req_b[i*W +: W];
`ifdef ADDER_ARB_ACCUM_EN
        if (req_acc[i]) sel_b = acc_q[i];
`endif
        sel_cin = req_cin[i];
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    cin_d     = cin_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
`ifdef ADDER_ARB_ACCUM_EN
    acc_d     = acc_q;
`endif
    req_ready = '0;
    rsp_valid = 1'b0;

    case (state_q)
      IDLE: begin
        // Gated by rst so no requester sees a grant that reset will drop.
        if (!rst && (|grant)) begin
          req_ready = grant;
          id_d      = sel_id;
          a_d       = sel_a;
          b_d       = sel_b;
          cin_d     = sel_cin;
          state_d   = CALC;
        end
      end
      CALC: begin
        sum_d   = add_sum;
        cout_d  = add_cout;
        state_d = HOLD;
      end
      HOLD: begin
        rsp_valid = !rst;
        if (rsp_ready) begin
          rr_ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
`ifdef ADDER_ARB_ACCUM_EN
          acc_d[id_q] = sum_q;
`endif
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
`ifdef ADDER_ARB_ACCUM_EN
      // NOTE: the accumulator bank is reset explicitly; running sums must
      // start from zero, unlike plain storage that could stay unreset.
      acc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
`ifdef ADDER_ARB_ACCUM_EN
      acc_q    <= acc_d;
`endif
    end
  end

  assign rsp_id   = id_q;
  assign rsp_sum  = sum_q;
  assign rsp_cout = cout_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed self-checking bench for adder_arbiter (NREQ=4, W=64).
// Inputs change 1 time unit after a rising edge; outputs are sampled 2 units
// after the edge.
module tb_adder_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 64;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0]   req_cin = '0;
`ifdef ADDER_ARB_ACCUM_EN
  logic [NREQ-1:0]   req_acc = '0;
`endif
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
`ifdef ADDER_ARB_ACCUM_EN
    .req_acc   (req_acc),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_cin[id]      = cin;
  endtask

  task automatic do_reset(input int cycles);
    rst       = 1'b1;
    req_valid = '0;
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  // Raise valid for one requester and wait (bounded) for its grant; on grant,
  // pass the handshake edge and drop valid. Returns in CALC at edge+1.
  task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, output bit granted);
    granted = 1'b0;
    set_req(id, a, b, cin);
    req_valid[id] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req_ready[id]) begin
        granted = 1'b1;
        break;
      end
      step();
    end
    if (granted) begin
      step();
      req_valid[id] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rsp_ready = 1'b1;
    rst       = 1'b1;
    set_req(0, 64'd1, 64'd16, 1'b0);
    req_valid = 4'b0001;
    step(); #1;
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++;
    if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
    checks++;
    if (rsp_sum !== 64'd0 || rsp_cout !== 1'b0) begin errors++; $display("FAIL reset_rsp_data: got %0h/%b expected 0/0", rsp_sum, rsp_cout); end
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", req_ready); end
    step();
    req_valid = '0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL single_calc: got valid=%b ready=%b expected 0/0000", rsp_valid, req_ready); end
    step(); #1;
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_latency: got rsp_valid=%b expected 1", rsp_valid); end
    checks++;
    if (rsp_id !== 2'd0 || rsp_sum !== 64'd17 || rsp_cout !== 1'b0) begin errors++; $display("FAIL single_result: got id=%0d sum=%0d cout=%b expected 0/17/0", rsp_id, rsp_sum, rsp_cout); end
    step(); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_release: got rsp_valid=%b expected 0", rsp_valid); end
  endtask

  task automatic test_overflow();
    bit g;
    issue(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, g);
    checks++;
    if (!g) begin errors++; $display("FAIL ovf_grant: got no grant expected grant to 2"); end
    step(); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin errors++; $display("FAIL ovf_rsp: got valid=%b id=%0d expected 1/2", rsp_valid, rsp_id); end
    checks++;
    if (rsp_sum !== 64'd0 || rsp_cout !== 1'b1) begin errors++; $display("FAIL ovf_sum: got sum=%0h cout=%b expected 0/1", rsp_sum, rsp_cout); end
    step();
  endtask

  task automatic test_round_robin();
    bit seen;
    logic [NREQ-1:0] exp_g;
    int exp_id;
    do_reset(1);
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 64'(i * 100), 64'd3, 1'b0);
    req_valid = 4'hF;
    for (int n = 0; n < 5; n++) begin
      exp_id = n % NREQ;
      exp_g  = 4'b0001 << exp_id;
      seen   = 1'b0;
      for (int c = 0; c < 6; c++) begin
        #1;
        if (req_ready !== 4'b0000) begin seen = 1'b1; break; end
        step();
      end
      checks++;
      if (!seen || req_ready !== exp_g) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", n, req_ready, exp_g); end
      step();
      step(); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== IDW'(exp_id)) begin errors++; $display("FAIL rr_id%0d: got valid=%b id=%0d expected 1/%0d", n, rsp_valid, rsp_id, exp_id); end
      checks++;
      if (rsp_sum !== 64'(exp_id * 100 + 3)) begin errors++; $display("FAIL rr_sum%0d: got %0d expected %0d", n, rsp_sum, exp_id * 100 + 3); end
      step();
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    bit g;
    rsp_ready = 1'b0;
    issue(1, 64'd7, 64'd8, 1'b1, g);
    checks++;
    if (!g) begin errors++; $display("FAIL bp_grant: got no grant expected grant to 1"); end
    step(); #1;
    set_req(0, 64'd1, 64'd1, 1'b0);
    req_valid[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 64'd16 || rsp_cout !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: got valid=%b id=%0d sum=%0d cout=%b expected 1/1/16/0", c, rsp_valid, rsp_id, rsp_sum, rsp_cout);
      end
      checks++;
      if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_no_grant%0d: got %b expected 0000", c, req_ready); end
      step();
    end
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_rst_ready: got %b expected 0000", req_ready); end
    step();
    rst = 1'b0;
    set_req(3, 64'd2, 64'd2, 1'b0);
    req_valid = 4'b1001;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_sum !== 64'd0) begin errors++; $display("FAIL bp_after_rst: got valid=%b id=%0d sum=%0d expected 0/0/0", rsp_valid, rsp_id, rsp_sum); end
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_ptr_zero: got %b expected 0001", req_ready); end
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(); #1;
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_ghost%0d: got rsp_valid=%b expected 0", c, rsp_valid); end
    end
  endtask

  task automatic test_withdrawal();
    bit g;
    rsp_ready = 1'b1;
    issue(3, 64'd40, 64'd2, 1'b0, g);
    checks++;
    if (!g) begin errors++; $display("FAIL wd_grant3: got no grant expected grant to 3"); end
    req_valid[1] = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL wd_calc_ready: got %b expected 0000", req_ready); end
    step();
    req_valid[1] = 1'b0;
    set_req(2, 64'd5, 64'd6, 1'b0);
    req_valid[2] = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_sum !== 64'd42) begin errors++; $display("FAIL wd_rsp3: got valid=%b id=%0d sum=%0d expected 1/3/42", rsp_valid, rsp_id, rsp_sum); end
    step(); #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL wd_next_grant: got %b expected 0100", req_ready); end
    step();
    req_valid = '0;
    step(); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 64'd11) begin errors++; $display("FAIL wd_rsp2: got valid=%b id=%0d sum=%0d expected 1/2/11", rsp_valid, rsp_id, rsp_sum); end
    for (int c = 0; c < 3; c++) begin
      step(); #1;
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wd_no_id1_%0d: got valid=%b id=%0d expected no response", c, rsp_valid, rsp_id); end
    end
  endtask

`ifdef ADDER_ARB_ACCUM_EN
  task automatic test_accumulate();
    bit g;
    rsp_ready  = 1'b1;
    req_acc[1] = 1'b0;
    issue(1, 64'd500, 64'd3, 1'b0, g);
    checks++;
    if (!g) begin errors++; $display("FAIL acc_grant0: got no grant expected grant to 1"); end
    step(); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 64'd503) begin errors++; $display("FAIL acc_first: got valid=%b sum=%0d expected 1/503", rsp_valid, rsp_sum); end
    step();
    req_acc[1] = 1'b1;
    issue(1, 64'd10, 64'd999, 1'b0, g);
    req_acc[1] = 1'b0;
    checks++;
    if (!g) begin errors++; $display("FAIL acc_grant1: got no grant expected grant to 1"); end
    step(); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 64'd513) begin errors++; $display("FAIL acc_second: got valid=%b sum=%0d expected 1/513", rsp_valid, rsp_sum); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_overflow();
    test_round_robin();
    test_backpressure();
    test_withdrawal();
`ifdef ADDER_ARB_ACCUM_EN
    test_accumulate();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
